// File: rtl/acq_sequencer_pkg.sv
// Shared definitions for the acquisition sequencer: state encoding,
// engage window length and default port widths.
package acq_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    ENGAGE   = 3'd2,
    RUN      = 3'd3,
    GAP      = 3'd4,
    ABORTING = 3'd5,
    FINISH   = 3'd6
  } state_t;

  // Cycles to wait in ENGAGE for the controller to report activity.
  localparam int ENGAGE_LIMIT = 4;

  localparam int TMO_W_DEFAULT     = 16;
  localparam int CNT_W_DEFAULT     = 8;
  localparam int ABORT_LEN_DEFAULT = 2;

endpackage

// File: rtl/acq_seq_timeout.sv
// Loadable down-counter clocked by an external tick strobe; flags expiry when
// a tick arrives while the count is 1. Saturates at zero.
module acq_seq_timeout #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] reload,
  input  logic         enable,
  input  logic         tick,
  output logic         expire
);

  logic [W-1:0] count;

  assign expire = enable && tick && (count == W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= reload;
    end else if (enable && tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// Runs a programmed number of back-to-back captures on the acquisition
// controller, with per-capture timeout, host cancel and RAM-full termination.
module acq_sequencer
  import acq_sequencer_pkg::*;
#(
  parameter int TMO_W     = TMO_W_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int ABORT_LEN = ABORT_LEN_DEFAULT
) (
  input  logic             CLK_MASTER,
  input  logic             RESETn,
  input  logic             TICK_250US,
  input  logic             SEQ_GO,
  input  logic             SEQ_CANCEL,
  input  logic [CNT_W-1:0] SEQ_COUNT,
  input  logic [TMO_W-1:0] SEQ_TIMEOUT,
  input  logic             ACQ_WAITING,
  input  logic             ACQ_ACQUIRING,
  input  logic             SR_R_FULL,
  output logic             ACQ_START,
  output logic             ACQ_ABORT,
  output logic             SEQ_BUSY,
  output logic             SEQ_DONE,
  output logic             SEQ_TIMEDOUT,
  output logic             SEQ_MEMFULL,
  output logic [CNT_W-1:0] SEQ_NDONE
);

  localparam logic [2:0] ENGAGE_LAST = 3'(ENGAGE_LIMIT - 1);
  localparam logic [7:0] ABORT_LAST  = 8'(ABORT_LEN - 1);

  state_t           state;
  logic             go_prev;
  logic [CNT_W-1:0] remain;
  logic [TMO_W-1:0] tmo_reload;
  logic [2:0]       eng_cnt;
  logic [7:0]       abort_cnt;
  logic             mem_seen;

  logic go_edge, status, mem_hit, capture_end;
  logic tmo_load, tmo_en, tmo_expire;

  assign go_edge  = SEQ_GO && !go_prev;
  assign status   = ACQ_WAITING || ACQ_ACQUIRING;
  assign mem_hit  = mem_seen || SR_R_FULL;
  assign tmo_load = (state == ARM);
  assign tmo_en   = ((state == ENGAGE) || (state == RUN)) && (tmo_reload != '0);

  // A controller that never reports activity is treated as a finished capture.
  assign capture_end = !status &&
                       ((state == RUN) || ((state == ENGAGE) && (eng_cnt == ENGAGE_LAST)));

  acq_seq_timeout #(.W(TMO_W)) u_timeout (
    .clk    (CLK_MASTER),
    .rst_n  (RESETn),
    .load   (tmo_load),
    .reload (tmo_reload),
    .enable (tmo_en),
    .tick   (TICK_250US),
    .expire (tmo_expire)
  );

  always_ff @(posedge CLK_MASTER or negedge RESETn) begin
    if (!RESETn) begin
      state        <= IDLE;
      go_prev      <= 1'b0;
      remain       <= '0;
      tmo_reload   <= '0;
      eng_cnt      <= '0;
      abort_cnt    <= '0;
      mem_seen     <= 1'b0;
      ACQ_START    <= 1'b0;
      ACQ_ABORT    <= 1'b0;
      SEQ_BUSY     <= 1'b0;
      SEQ_DONE     <= 1'b0;
      SEQ_TIMEDOUT <= 1'b0;
      SEQ_MEMFULL  <= 1'b0;
      SEQ_NDONE    <= '0;
    end else begin
      go_prev   <= SEQ_GO;
      ACQ_START <= 1'b0;
      SEQ_DONE  <= 1'b0;
      case (state)
        IDLE: begin
          if (go_edge && !SEQ_CANCEL) begin
            remain       <= SEQ_COUNT;
            tmo_reload   <= SEQ_TIMEOUT;
            SEQ_NDONE    <= '0;
            SEQ_TIMEDOUT <= 1'b0;
            SEQ_MEMFULL  <= 1'b0;
            SEQ_BUSY     <= 1'b1;
            if (SEQ_COUNT == '0) begin
              state    <= FINISH;
              SEQ_DONE <= 1'b1;
            end else begin
              state     <= ARM;
              ACQ_START <= 1'b1;
            end
          end
        end
        ARM: begin
          eng_cnt  <= '0;
          mem_seen <= SR_R_FULL;
          if (SEQ_CANCEL) begin
            state     <= ABORTING;
            ACQ_ABORT <= 1'b1;
            abort_cnt <= '0;
          end else begin
            state <= ENGAGE;
          end
        end
        ENGAGE, RUN: begin
          mem_seen <= mem_hit;
          if (state == ENGAGE) eng_cnt <= eng_cnt + 3'd1;
          // Priority: cancel, then timeout, then capture completion.
          if (SEQ_CANCEL) begin
            state     <= ABORTING;
            ACQ_ABORT <= 1'b1;
            abort_cnt <= '0;
          end else if (tmo_expire) begin
            SEQ_TIMEDOUT <= 1'b1;
            state        <= ABORTING;
            ACQ_ABORT    <= 1'b1;
            abort_cnt    <= '0;
          end else if ((state == ENGAGE) && status) begin
            state <= RUN;
          end else if (capture_end) begin
            SEQ_NDONE <= SEQ_NDONE + CNT_W'(1);
            remain    <= remain - CNT_W'(1);
            if (mem_hit) begin
              SEQ_MEMFULL <= 1'b1;
              state       <= FINISH;
              SEQ_DONE    <= 1'b1;
            end else if (remain == CNT_W'(1)) begin
              state    <= FINISH;
              SEQ_DONE <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (SEQ_CANCEL) begin
            state     <= ABORTING;
            ACQ_ABORT <= 1'b1;
            abort_cnt <= '0;
          end else begin
            state     <= ARM;
            ACQ_START <= 1'b1;
          end
        end
        ABORTING: begin
          if (abort_cnt == ABORT_LAST) begin
            ACQ_ABORT <= 1'b0;
            state     <= FINISH;
            SEQ_DONE  <= 1'b1;
          end else begin
            abort_cnt <= abort_cnt + 8'd1;
          end
        end
        FINISH: begin
          state    <= IDLE;
          SEQ_BUSY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: a small controller model drives status,
// and each sequence's expected outcome is queued and checked at SEQ_DONE.
module tb_acq_sequencer;

  localparam int TMO_W = 16;
  localparam int CNT_W = 8;

  logic             CLK_MASTER = 1'b0;
  logic             RESETn     = 1'b0;
  logic             SEQ_GO     = 1'b0;
  logic             SEQ_CANCEL = 1'b0;
  logic [CNT_W-1:0] SEQ_COUNT  = '0;
  logic [TMO_W-1:0] SEQ_TIMEOUT = '0;
  logic             TICK_250US, ACQ_WAITING, ACQ_ACQUIRING, SR_R_FULL;
  logic             ACQ_START, ACQ_ABORT, SEQ_BUSY, SEQ_DONE, SEQ_TIMEDOUT, SEQ_MEMFULL;
  logic [CNT_W-1:0] SEQ_NDONE;

  // Controller model: 0 = waiting 2 then acquiring 10, 1 = stuck waiting,
  // 2 = never responds, 3 = bench drives status by hand.
  int   mode = 0;
  int   mdl_t = -1;
  logic mdl_wait = 1'b0, mdl_acq = 1'b0, mdl_full = 1'b0, gen_tick = 1'b0;
  logic man_wait = 1'b0, man_acq = 1'b0, man_tick = 1'b0;
  bit   tick_on = 1'b0;
  int   full_capture = 0;
  int   cyc_cnt = 0;

  assign ACQ_WAITING   = (mode == 3) ? man_wait : mdl_wait;
  assign ACQ_ACQUIRING = (mode == 3) ? man_acq  : mdl_acq;
  assign TICK_250US    = man_tick | gen_tick;
  assign SR_R_FULL     = mdl_full;

  int   starts = 0, aborts = 0, done_cnt = 0, tick_cnt = 0, tick_at_abort = -1, wide_cnt = 0;
  logic start_prev = 1'b0, abort_prev = 1'b0;
  int   checks = 0, passed = 0, fails = 0;

  typedef struct {
    int ndone;
    int tmo;
    int mem;
    int starts;
    int aborts;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  acq_sequencer dut (
    .CLK_MASTER    (CLK_MASTER),
    .RESETn        (RESETn),
    .TICK_250US    (TICK_250US),
    .SEQ_GO        (SEQ_GO),
    .SEQ_CANCEL    (SEQ_CANCEL),
    .SEQ_COUNT     (SEQ_COUNT),
    .SEQ_TIMEOUT   (SEQ_TIMEOUT),
    .ACQ_WAITING   (ACQ_WAITING),
    .ACQ_ACQUIRING (ACQ_ACQUIRING),
    .SR_R_FULL     (SR_R_FULL),
    .ACQ_START     (ACQ_START),
    .ACQ_ABORT     (ACQ_ABORT),
    .SEQ_BUSY      (SEQ_BUSY),
    .SEQ_DONE      (SEQ_DONE),
    .SEQ_TIMEDOUT  (SEQ_TIMEDOUT),
    .SEQ_MEMFULL   (SEQ_MEMFULL),
    .SEQ_NDONE     (SEQ_NDONE)
  );

  always #5 CLK_MASTER = ~CLK_MASTER;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model runs on the falling edge; the bench acts 1 time unit later.
  always @(negedge CLK_MASTER) begin
    if (!RESETn) begin
      mdl_t = -1; mdl_wait = 1'b0; mdl_acq = 1'b0; mdl_full = 1'b0; gen_tick = 1'b0;
      start_prev = 1'b0; abort_prev = 1'b0;
    end else begin
      cyc_cnt++;
      if (ACQ_START && start_prev) wide_cnt++;
      if (ACQ_ABORT && !abort_prev) tick_at_abort = tick_cnt;
      if (ACQ_ABORT) begin aborts++; mdl_t = -1; end
      if (ACQ_START) begin starts++; mdl_t = 0; tick_cnt = 0; end
      else if (mdl_t >= 0) mdl_t++;
      if (SEQ_DONE) begin
        done_cnt++;
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = sb.pop_front();
          $display("seq done: ndone=%0d tmo=%0d mem=%0d starts=%0d aborts=%0d",
                   SEQ_NDONE, SEQ_TIMEDOUT, SEQ_MEMFULL, starts, aborts);
          chk("ndone",    32'(SEQ_NDONE),    e.ndone);
          chk("timedout", 32'(SEQ_TIMEDOUT), e.tmo);
          chk("memfull",  32'(SEQ_MEMFULL),  e.mem);
          chk("starts",   starts,            e.starts);
          chk("aborts",   aborts,            e.aborts);
        end
      end
      case (mode)
        0: begin
          mdl_wait = (mdl_t >= 0) && (mdl_t < 2);
          mdl_acq  = (mdl_t >= 2) && (mdl_t < 12);
          if (mdl_t >= 12) mdl_t = -1;
        end
        1: begin mdl_wait = (mdl_t >= 0); mdl_acq = 1'b0; end
        default: begin mdl_wait = 1'b0; mdl_acq = 1'b0; end
      endcase
      mdl_full = (full_capture != 0) && (starts == full_capture) && (mdl_t == 5);
      gen_tick = tick_on && (cyc_cnt % 3 == 0);
      if (gen_tick && !ACQ_START) tick_cnt++;
      start_prev = ACQ_START;
      abort_prev = ACQ_ABORT;
    end
  end

  task automatic cyc();
    @(negedge CLK_MASTER);
    #1;
  endtask

  task automatic start_seq(input int cnt, input int tmo, input int x_ndone, input int x_tmo,
                           input int x_mem, input int x_starts, input int x_aborts);
    exp_t x;
    x.ndone = x_ndone; x.tmo = x_tmo; x.mem = x_mem; x.starts = x_starts; x.aborts = x_aborts;
    sb.push_back(x);
    starts = 0;
    aborts = 0;
    SEQ_COUNT   = CNT_W'(cnt);
    SEQ_TIMEOUT = TMO_W'(tmo);
    SEQ_GO      = 1'b1;
  endtask

  task automatic wait_done(input int max, input string tag);
    int d0 = done_cnt;
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      cyc();
      if (done_cnt != d0) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    cyc();
    cyc();
  endtask

  initial begin
    int d0;
    bit hit;

    repeat (3) cyc();
    chk("rst_start",    32'(ACQ_START),    0);
    chk("rst_abort",    32'(ACQ_ABORT),    0);
    chk("rst_busy",     32'(SEQ_BUSY),     0);
    chk("rst_done",     32'(SEQ_DONE),     0);
    chk("rst_timedout", 32'(SEQ_TIMEDOUT), 0);
    chk("rst_memfull",  32'(SEQ_MEMFULL),  0);
    chk("rst_ndone",    32'(SEQ_NDONE),    0);
    RESETn = 1'b1;
    repeat (2) cyc();

    // Three normal captures, no timeout.
    mode = 0;
    start_seq(3, 0, 3, 0, 0, 3, 0);
    cyc(); SEQ_GO = 1'b0;
    wait_done(400, "normal");

    // Stuck in WAITING, timeout of 5 ticks.
    mode = 1; tick_on = 1'b1;
    start_seq(2, 5, 0, 1, 0, 1, 2);
    cyc(); SEQ_GO = 1'b0;
    wait_done(300, "timeout");
    chk("ticks_to_abort", tick_at_abort, 5);
    tick_on = 1'b0;
    cyc();

    // RAM full during capture 2 ends the sequence after that capture.
    mode = 0; full_capture = 2;
    start_seq(4, 0, 2, 0, 1, 2, 0);
    cyc(); SEQ_GO = 1'b0;
    wait_done(400, "memfull");
    full_capture = 0;

    // Controller never reports activity: captures complete via engage limit.
    mode = 2;
    start_seq(2, 0, 2, 0, 0, 2, 0);
    cyc(); SEQ_GO = 1'b0;
    wait_done(100, "engage_limit");

    // Cancel, timeout expiry and status drop all on one edge: cancel wins.
    mode = 3;
    start_seq(5, 2, 0, 0, 0, 1, 2);
    cyc(); SEQ_GO = 1'b0;
    for (int i = 0; i < 10 && starts == 0; i++) cyc();
    man_acq = 1'b1;
    cyc(); cyc();
    man_tick = 1'b1;
    cyc();
    man_tick = 1'b0;
    cyc();
    man_tick = 1'b1; man_acq = 1'b0; SEQ_CANCEL = 1'b1;
    cyc();
    man_tick = 1'b0; SEQ_CANCEL = 1'b0;
    chk("cancel_abort_high", 32'(ACQ_ABORT), 1);
    wait_done(50, "cancel");

    // Zero count: done one cycle after the GO edge, busy for one cycle.
    mode = 0;
    start_seq(0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("cnt0_busy", 32'(SEQ_BUSY), 1);
    chk("cnt0_done", 32'(SEQ_DONE), 1);
    cyc();
    chk("cnt0_busy_after", 32'(SEQ_BUSY), 0);
    chk("cnt0_done_after", 32'(SEQ_DONE), 0);
    SEQ_GO = 1'b0;
    repeat (2) cyc();

    // GO held high across sequence end must not retrigger.
    start_seq(1, 0, 1, 0, 0, 1, 0);
    wait_done(200, "held_go");
    repeat (20) cyc();
    chk("no_retrigger_starts", starts, 1);
    chk("no_retrigger_busy", 32'(SEQ_BUSY), 0);
    SEQ_GO = 1'b0;
    repeat (2) cyc();

    // Reset mid-RUN of capture 2.
    start_seq(3, 0, 0, 0, 0, 0, 0);
    cyc(); SEQ_GO = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cyc();
      if (SEQ_NDONE == CNT_W'(1) && ACQ_ACQUIRING) hit = 1'b1;
    end
    chk("reached_run2", 32'(hit), 1);
    RESETn = 1'b0;
    #1;
    chk("mid_rst_start",    32'(ACQ_START),    0);
    chk("mid_rst_abort",    32'(ACQ_ABORT),    0);
    chk("mid_rst_busy",     32'(SEQ_BUSY),     0);
    chk("mid_rst_done",     32'(SEQ_DONE),     0);
    chk("mid_rst_timedout", 32'(SEQ_TIMEDOUT), 0);
    chk("mid_rst_memfull",  32'(SEQ_MEMFULL),  0);
    chk("mid_rst_ndone",    32'(SEQ_NDONE),    0);
    sb.delete();
    repeat (3) cyc();
    RESETn = 1'b1;
    d0 = done_cnt;
    starts = 0;
    repeat (10) cyc();
    chk("post_rst_busy", 32'(SEQ_BUSY), 0);
    chk("post_rst_no_done", done_cnt, d0);
    chk("post_rst_no_start", starts, 0);

    // Sequencer is usable again after reset.
    start_seq(1, 0, 1, 0, 0, 1, 0);
    cyc(); SEQ_GO = 1'b0;
    wait_done(200, "post_reset");

    chk("start_width", wide_cnt, 0);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
- Sequences the acquisition controller through a programmed number of back-to-back capture cycles (e.g. multi-revolution reads) without host intervention.
- Per capture: pulses ACQ_START, tracks the controller's WAITING/ACQUIRING status and enforces a per-capture timeout in 250us ticks.
- Issues ACQ_ABORT on timeout or host cancel.
- Sits between the host register file and the acquisition controller, in the CLK_MASTER domain.

Parameters:
- TMO_W, 16, width of timeout counter and SEQ_TIMEOUT port (units of 250us ticks).
- CNT_W, 8, width of capture count and completed-capture counter.
- ABORT_LEN, 2, number of cycles ACQ_ABORT is held high.

Ports:
- CLK_MASTER  in  1  master clock; all logic on rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- TICK_250US  in  1  single-cycle strobe every 250us, already synchronous to CLK_MASTER.
- SEQ_GO  in  1  start sequence; level, edge-detected internally.
- SEQ_CANCEL  in  1  cancel sequence; level, has priority over SEQ_GO.
- SEQ_COUNT  in  CNT_W  number of captures to run; sampled on accepted GO.
- SEQ_TIMEOUT  in  TMO_W  per-capture timeout in ticks, 0 = disabled; sampled on accepted GO.
- ACQ_WAITING  in  1  controller status: waiting for trigger.
- ACQ_ACQUIRING  in  1  controller status: acquiring.
- SR_R_FULL  in  1  acquisition RAM full.
- ACQ_START  out  1  start strobe to controller.
- ACQ_ABORT  out  1  abort to controller.
- SEQ_BUSY  out  1  sequence in progress.
- SEQ_DONE  out  1  one-cycle pulse at end of sequence, for any reason.
- SEQ_TIMEDOUT  out  1  sticky: last sequence ended by timeout.
- SEQ_MEMFULL  out  1  sticky: last sequence ended by RAM full.
- SEQ_NDONE  out  CNT_W  captures completed in current/last sequence.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
- Accepted GO: rising edge of SEQ_GO (registered previous value) while in IDLE and SEQ_CANCEL=0. The edge is ignored in any other state.
- On accepted GO:
  - Latch SEQ_COUNT into REMAIN and SEQ_TIMEOUT into TMO_RELOAD.
  - Clear SEQ_NDONE, SEQ_TIMEDOUT and SEQ_MEMFULL.
- States:
  - IDLE:
    - Accepted GO with SEQ_COUNT=0 -> FINISH; no ACQ_START is issued.
    - Accepted GO otherwise -> ARM.
  - ARM:
    - ACQ_START=1 for exactly this one cycle; load the timeout counter from TMO_RELOAD.
    - -> ENGAGE.
  - ENGAGE: wait until ACQ_WAITING or ACQ_ACQUIRING is 1, then -> RUN.
    - If neither has asserted after 4 cycles in ENGAGE, the capture counts as complete and proceeds as a RUN exit; this covers zero-length captures.
  - RUN: wait until ACQ_WAITING=0 and ACQ_ACQUIRING=0. Then:
    - SEQ_NDONE += 1 and REMAIN -= 1.
    - If SR_R_FULL was seen at any point during this capture: set SEQ_MEMFULL, -> FINISH.
    - Else if REMAIN reaches 0: -> FINISH.
    - Else: -> GAP.
  - GAP: one idle cycle so the controller is back in idle. -> ARM.
  - ABORTING:
    - ACQ_ABORT=1 for ABORT_LEN cycles, then -> FINISH.
    - The capture that was in progress does not increment SEQ_NDONE.
  - FINISH: SEQ_DONE=1 for one cycle, -> IDLE.
- SEQ_BUSY=1 in every state except IDLE.
- Timeout:
  - Active in ENGAGE and RUN when TMO_RELOAD≠0.
  - Decrements on TICK_250US.
  - A tick arriving while the counter is 1: set SEQ_TIMEDOUT, -> ABORTING.
  - Counter saturates at 0 and does not wrap.
- Cancel: SEQ_CANCEL=1 in ARM, ENGAGE, RUN or GAP -> ABORTING next cycle. The ACQ_START already issued in ARM is not retracted.
- Simultaneous events in the same cycle, by priority:
  1. Cancel.
  2. Timeout.
  3. Capture completion.
- SEQ_NDONE wraps only if CNT_W overflows, which cannot occur since it is ≤ SEQ_COUNT.
- RESETn asserted mid-sequence: immediate return to IDLE with outputs 0. No ABORT is emitted; the controller is reset by its own path.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, ARM, ENGAGE, RUN, GAP, ABORTING, FINISH, 3 bits;
  - ENGAGE_LIMIT=4;
  - default widths.
- One natural sub-module: acq_seq_timeout. It is the loadable down-counter with enable, tick input and expiry flag, reusable for the step-rate logic.

Test Plan:
- COUNT=3, TIMEOUT=0; controller model sets WAITING 2 cycles, then ACQUIRING 10 cycles -> three 1-cycle ACQ_START pulses each separated by GAP; SEQ_NDONE=3; one SEQ_DONE; TIMEDOUT=0.
- COUNT=2, TIMEOUT=5; model stays WAITING forever -> on 5th tick ACQ_ABORT high 2 cycles; SEQ_TIMEDOUT=1; SEQ_NDONE=0; SEQ_DONE pulses.
- COUNT=4; SR_R_FULL pulses during capture 2 -> sequence ends after capture 2; SEQ_MEMFULL=1; SEQ_NDONE=2; no 3rd ACQ_START.
- COUNT=5; SEQ_CANCEL asserted in RUN of capture 1 on the same cycle that the timeout expires and the status drops -> ABORTING entered; TIMEDOUT=0; SEQ_NDONE=0.
- COUNT=0 -> no ACQ_START; SEQ_DONE pulses 1 cycle after GO edge; SEQ_BUSY high for 1 cycle.
- SEQ_GO held high across sequence end; RESETn pulsed low mid-RUN -> no retrigger without a new rising edge; after reset all outputs 0, state IDLE.
